// File: rtl/rail_monitor.sv
// -----------------------------------------------------------------------------
// rail_monitor
//
// Rail sensing front end for a bank of 1-bit sigma-delta isolated modulators.
// Generates the shared modulator clock. Decimates each bitstream with an
// accumulate-and-dump (sinc1) filter into DATA_W-bit codes. Checks every code
// against a per-channel window, debounces the result over consecutive samples,
// and raises sticky per-channel faults plus a summary alarm.
//
// Ports
//   sclk        in   system clock
//   rstn        in   synchronous active-low reset
//   sdat        in   [NUMCH]            modulator bitstreams, already in sclk domain
//   mclk        out                     modulator clock, 50% duty, shared
//   lo_thresh   in   [NUMCH][DATA_W]    lower window limit (inclusive valid)
//   hi_thresh   in   [NUMCH][DATA_W]    upper window limit (inclusive valid)
//   fault_clr   in   [NUMCH]            sticky fault clear pulse
//   outData     out  [NUMCH][DATA_W]    latest decimated code per channel
//   data_ready  out                     one-cycle strobe, outData updated
//   fault       out  [NUMCH]            sticky fault flags
//   alarm       out                     registered OR of fault
// -----------------------------------------------------------------------------
module rail_monitor #(
  parameter int NUMCH     = 5,
  parameter int OSR       = 256,
  parameter int DATA_W    = 8,
  parameter int MCLK_DIV  = 10,
  parameter int FAULT_CNT = 4
) (
  input  logic                          sclk,
  input  logic                          rstn,
  input  logic [NUMCH-1:0]              sdat,
  output logic                          mclk,
  input  logic [NUMCH-1:0][DATA_W-1:0]  lo_thresh,
  input  logic [NUMCH-1:0][DATA_W-1:0]  hi_thresh,
  input  logic [NUMCH-1:0]              fault_clr,
  output logic [NUMCH-1:0][DATA_W-1:0]  outData,
  output logic                          data_ready,
  output logic [NUMCH-1:0]              fault,
  output logic                          alarm
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int LOG2_OSR = $clog2(OSR);
  // One extra bit so a window of all ones (sum == OSR) does not wrap.
  localparam int ACC_W    = LOG2_OSR + 1;
  localparam int SHIFT    = LOG2_OSR - DATA_W;
  localparam int HALF_DIV = MCLK_DIV / 2;
  localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int CNT_W    = $clog2(FAULT_CNT + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [LOG2_OSR-1:0] BIT_LAST = LOG2_OSR'(OSR - 1);
  localparam logic [ACC_W-1:0]    SUM_MAX  = ACC_W'(OSR - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(FAULT_CNT);

  // Clip the window sum to full scale, then drop the excess resolution.
  function automatic logic [DATA_W-1:0] to_code(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] clipped;
    clipped = (sum > SUM_MAX) ? SUM_MAX : sum;
    return DATA_W'(clipped >> SHIFT);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]                div_q,       div_d;
  logic                            mclk_q,      mclk_d;
  logic [LOG2_OSR-1:0]             bit_cnt_q,   bit_cnt_d;
  logic [NUMCH-1:0][ACC_W-1:0]     acc_q,       acc_d;
  logic                            discard_q,   discard_d;
  logic [NUMCH-1:0][DATA_W-1:0]    outdata_q,   outdata_d;
  logic                            data_rdy_q,  data_rdy_d;
  logic [NUMCH-1:0][CNT_W-1:0]     cnt_q,       cnt_d;
  logic [NUMCH-1:0]                fault_q,     fault_d;
  logic                            alarm_q,     alarm_d;

  // Intermediate decode
  logic                            half_done;
  logic                            bit_strobe;
  logic                            last_bit;
  logic [NUMCH-1:0][ACC_W-1:0]     acc_sum;
  logic [NUMCH-1:0]                out_win;
  logic [NUMCH-1:0][CNT_W-1:0]     cnt_step;
  logic [NUMCH-1:0]                set_fault;

  // ---------------------------------------------------------------------------
  // Clock divider, bit strobe and sinc1 decimator
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it holding its old value and synthesis never infers a latch.
    div_d      = div_q + 1'b1;
    mclk_d     = mclk_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    acc_sum    = '0;
    discard_d  = discard_q;
    outdata_d  = outdata_q;
    data_rdy_d = 1'b0;

    half_done = (div_q == DIV_LAST);
    if (half_done) begin
      div_d  = '0;
      mclk_d = ~mclk_q;
    end

    // The bit strobe is the sclk edge where the registered mclk falls.
    bit_strobe = half_done && mclk_q;
    last_bit   = bit_strobe && (bit_cnt_q == BIT_LAST);

    // OSR is a power of two, so the counter wraps to 0 by itself.
    if (bit_strobe) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    for (int i = 0; i < NUMCH; i++) begin
      acc_sum[i] = acc_q[i] + ACC_W'(sdat[i]);
      if (bit_strobe) begin
        // Dump on the final bit: the captured sum already includes it, and the
        // next window starts empty so the following strobe is not lost.
        acc_d[i] = last_bit ? '0 : acc_sum[i];
      end
    end

    if (last_bit) begin
      if (discard_q) begin
        // The first window after reset may start mid-frame in the modulator;
        // drop it silently.
        discard_d = 1'b0;
      end else begin
        data_rdy_d = 1'b1;
        for (int i = 0; i < NUMCH; i++) begin
          outdata_d[i] = to_code(acc_sum[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window check, debounce and sticky faults
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    out_win   = '0;
    cnt_step  = cnt_q;
    set_fault = '0;

    for (int i = 0; i < NUMCH; i++) begin
      // With lo > hi both conditions cannot fail together, so every code is
      // out of window.
      out_win[i] = (outdata_q[i] < lo_thresh[i]) || (outdata_q[i] > hi_thresh[i]);

      if (data_rdy_q) begin
        if (out_win[i]) begin
          cnt_step[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
        end else begin
          cnt_step[i] = '0;
        end
      end

      set_fault[i] = data_rdy_q && out_win[i] && (cnt_step[i] == CNT_MAX);

      // Set beats clear so a fault arriving with a clear is never lost.
      if (set_fault[i]) begin
        fault_d[i] = 1'b1;
        cnt_d[i]   = CNT_MAX;
      end else if (fault_clr[i]) begin
        fault_d[i] = 1'b0;
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i]   = cnt_step[i];
      end
    end

    alarm_d = |fault_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      // NOTE: the accumulator array is reset along with the control state;
      // a reset mid-window must not leak a partial sum into the next code.
      div_q      <= '0;
      mclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      discard_q  <= 1'b1;
      outdata_q  <= '0;
      data_rdy_q <= 1'b0;
      cnt_q      <= '0;
      fault_q    <= '0;
      alarm_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      div_q      <= div_d;
      mclk_q     <= mclk_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      discard_q  <= discard_d;
      outdata_q  <= outdata_d;
      data_rdy_q <= data_rdy_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      alarm_q    <= alarm_d;
    end
  end

  assign mclk       = mclk_q;
  assign outData    = outdata_q;
  assign data_ready = data_rdy_q;
  assign fault      = fault_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_rail_monitor.sv
// -----------------------------------------------------------------------------
// tb_rail_monitor
//
// Directed bench for rail_monitor with NUMCH=2, OSR=16, DATA_W=4, MCLK_DIV=2,
// FAULT_CNT=3 and a 4..12 window. Each channel's bitstream is a 16-bit pattern
// rotated one bit per modulator strobe, so any full window carries exactly
// popcount(pattern) ones regardless of alignment.
// -----------------------------------------------------------------------------
module tb_rail_monitor;

  localparam int NUMCH     = 2;
  localparam int OSR       = 16;
  localparam int DATA_W    = 4;
  localparam int MCLK_DIV  = 2;
  localparam int FAULT_CNT = 3;
  localparam int PERIOD    = OSR * MCLK_DIV;

  logic                         sclk = 1'b0;
  logic                         rstn;
  logic [NUMCH-1:0]             sdat;
  logic                         mclk;
  logic [NUMCH-1:0][DATA_W-1:0] lo_thresh;
  logic [NUMCH-1:0][DATA_W-1:0] hi_thresh;
  logic [NUMCH-1:0]             fault_clr;
  logic [NUMCH-1:0][DATA_W-1:0] outData;
  logic                         data_ready;
  logic [NUMCH-1:0]             fault;
  logic                         alarm;

  int checks = 0;
  int errors = 0;

  logic [15:0] pat [NUMCH];
  logic [3:0]  sidx;

  rail_monitor #(
    .NUMCH    (NUMCH),
    .OSR      (OSR),
    .DATA_W   (DATA_W),
    .MCLK_DIV (MCLK_DIV),
    .FAULT_CNT(FAULT_CNT)
  ) dut (
    .sclk      (sclk),
    .rstn      (rstn),
    .sdat      (sdat),
    .mclk      (mclk),
    .lo_thresh (lo_thresh),
    .hi_thresh (hi_thresh),
    .fault_clr (fault_clr),
    .outData   (outData),
    .data_ready(data_ready),
    .fault     (fault),
    .alarm     (alarm)
  );

  always #5 sclk = ~sclk;

  // Bitstream driver: when mclk is high the next edge is a strobe, so present
  // the next pattern bit shortly after the current edge.
  initial begin
    sdat = '0;
    sidx = '0;
    forever begin
      @(posedge sclk);
      #2;
      if (mclk === 1'b1) begin
        for (int c = 0; c < NUMCH; c++) sdat[c] = pat[c][sidx];
        sidx = sidx + 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // Returns on the negedge where data_ready is seen high.
  task automatic wait_dr(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      @(negedge sclk);
      if (data_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: data_ready got 0 expected 1 within %0d cycles", tag, 3 * PERIOD);
    end
  endtask

  // Counts sclk cycles from release to the first data_ready, checking that
  // outData stays 0 through the discarded window.
  task automatic count_first(input string tag, output int first);
    first = 0;
    for (int k = 1; k <= 4 * PERIOD && first == 0; k++) begin
      @(negedge sclk);
      if (k <= 8) begin
        checks++;
        if (mclk !== k[0]) begin
          errors++;
          $display("FAIL %s_mclk_toggle cycle %0d: got %b expected %b", tag, k, mclk, k[0]);
        end
      end
      if (data_ready === 1'b1) begin
        first = k;
      end else begin
        checks++;
        if (outData !== '0) begin
          errors++;
          $display("FAIL %s_discard cycle %0d: outData got %h expected 0", tag, k, outData);
        end
      end
    end
    checks++;
    if (first != 2 * PERIOD) begin
      errors++;
      $display("FAIL %s_first_ready: got %0d cycles expected %0d", tag, first, 2 * PERIOD);
    end
  endtask

  task automatic test_reset;
    int first;
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      checks++;
      if ({mclk, data_ready, alarm, fault, outData} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got mclk=%b dr=%b alarm=%b fault=%b out=%h expected all 0",
                 mclk, data_ready, alarm, fault, outData);
      end
    end
    rstn = 1'b1;
    count_first("reset", first);
    checks++;
    if (outData[0] !== 4'd15) begin
      errors++;
      $display("FAIL ones_saturate: outData[0] got %0d expected 15", outData[0]);
    end
    checks++;
    if (outData[1] !== 4'd8) begin
      errors++;
      $display("FAIL alternating: outData[1] got %0d expected 8", outData[1]);
    end
  endtask

  task automatic test_transfer;
    int  gap;
    bit  seen;
    // Code 15 is above hi: first out-of-window sample, no fault yet.
    @(negedge sclk);
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_width: data_ready got %b expected 0", data_ready);
    end
    checks++;
    if (fault !== 2'b00) begin
      errors++;
      $display("FAIL fault_after_1: fault got %b expected 00", fault);
    end
    gap  = 1;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      @(negedge sclk);
      gap++;
      if (data_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (gap != PERIOD) begin
      errors++;
      $display("FAIL ready_period: got %0d cycles expected %0d", gap, PERIOD);
    end
    checks++;
    if (outData !== {4'd8, 4'd15}) begin
      errors++;
      $display("FAIL steady_codes: outData got %h expected 8f", outData);
    end
    // Switch ch0 to zeros in the middle of a window.
    step(6);
    pat[0] = 16'h0000;
    wait_dr("switch_mixed");
    wait_dr("switch_clean");
    checks++;
    if (outData !== {4'd8, 4'd0}) begin
      errors++;
      $display("FAIL switch_zero: outData got %h expected 80", outData);
    end
    // Start the next tests from a clean fault/counter state.
    step(3);
    fault_clr = 2'b11;
    step(1);
    fault_clr = 2'b00;
    checks++;
    if (fault !== 2'b00) begin
      errors++;
      $display("FAIL clear_all: fault got %b expected 00", fault);
    end
    step(1);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL clear_all_alarm: alarm got %b expected 0", alarm);
    end
  endtask

  task automatic test_debounce;
    // Sequence of ch0 codes: 0, 0, 8, 0, 0, 0 -> fault only after the last.
    // Pattern changes are applied on the data_ready cycle so the next window
    // is made entirely of the new pattern.
    logic [15:0] next_pat [6];
    logic [3:0]  exp_code [6];
    logic        exp_flt  [6];
    next_pat = '{16'h0000, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h5555};
    exp_code = '{4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0};
    exp_flt  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      wait_dr("debounce");
      pat[0] = next_pat[s];
      checks++;
      if (outData[0] !== exp_code[s]) begin
        errors++;
        $display("FAIL debounce_code[%0d]: got %0d expected %0d", s, outData[0], exp_code[s]);
      end
      step(1);
      checks++;
      if (fault[0] !== exp_flt[s]) begin
        errors++;
        $display("FAIL debounce_fault[%0d]: got %b expected %b", s, fault[0], exp_flt[s]);
      end
    end
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_latency: alarm got %b expected 0", alarm);
    end
    step(1);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_set: alarm got %b expected 1", alarm);
    end
  endtask

  task automatic test_sticky;
    // Back in window: fault must hold.
    wait_dr("sticky");
    checks++;
    if (outData[0] !== 4'd8) begin
      errors++;
      $display("FAIL sticky_code: got %0d expected 8", outData[0]);
    end
    step(1);
    checks++;
    if (fault[0] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold: fault[0] got %b expected 1", fault[0]);
    end
    step(3);
    fault_clr = 2'b01;
    step(1);
    fault_clr = 2'b00;
    checks++;
    if (fault[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_pulse: fault[0] got %b expected 0", fault[0]);
    end
    step(1);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL clear_alarm: alarm got %b expected 0", alarm);
    end
    // Three zero windows, with a clear coinciding with the third set.
    wait_dr("clr_set_a");
    pat[0] = 16'h0000;
    wait_dr("clr_set_b");
    wait_dr("clr_set_c");
    wait_dr("clr_set_d");
    fault_clr = 2'b01;
    pat[0]    = 16'h5555;
    step(1);
    fault_clr = 2'b00;
    checks++;
    if (fault[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_set: fault[0] got %b expected 1", fault[0]);
    end
    step(3);
    fault_clr = 2'b01;
    step(1);
    fault_clr = 2'b00;
    checks++;
    if (fault !== 2'b00) begin
      errors++;
      $display("FAIL clear_after_set: fault got %b expected 00", fault);
    end
  endtask

  task automatic test_bounds;
    // Codes exactly at lo (4) and hi (12) are valid.
    wait_dr("bounds_start");
    pat[0] = 16'h1111;
    pat[1] = 16'h7777;
    for (int s = 0; s < 3; s++) begin
      wait_dr("bounds");
      checks++;
      if (outData !== {4'd12, 4'd4}) begin
        errors++;
        $display("FAIL bounds_code[%0d]: outData got %h expected c4", s, outData);
      end
      step(1);
      checks++;
      if (fault !== 2'b00) begin
        errors++;
        $display("FAIL bounds_fault[%0d]: fault got %b expected 00", s, fault);
      end
    end
    // Inverted window: every sample is out of window.
    step(2);
    lo_thresh = {4'd13, 4'd13};
    hi_thresh = {4'd2, 4'd2};
    pat[0]    = 16'h5555;
    pat[1]    = 16'h5555;
    for (int s = 0; s < 3; s++) begin
      wait_dr("inverted");
      step(1);
      checks++;
      if (fault !== ((s == 2) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL inverted_fault[%0d]: fault got %b expected %b", s, fault,
                 (s == 2) ? 2'b11 : 2'b00);
      end
    end
    step(1);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL inverted_alarm: alarm got %b expected 1", alarm);
    end
  endtask

  task automatic test_mid_reset;
    int first;
    lo_thresh = {4'd4, 4'd4};
    hi_thresh = {4'd12, 4'd12};
    wait_dr("mid_reset");
    step(PERIOD / 2);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    checks++;
    if ({mclk, data_ready, alarm, fault, outData} !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: got mclk=%b dr=%b alarm=%b fault=%b out=%h expected all 0",
               mclk, data_ready, alarm, fault, outData);
    end
    count_first("mid_reset", first);
    checks++;
    if (outData !== {4'd8, 4'd8}) begin
      errors++;
      $display("FAIL mid_reset_codes: outData got %h expected 88", outData);
    end
    step(1);
    checks++;
    if (fault !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_fault: fault got %b expected 00", fault);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    fault_clr = '0;
    lo_thresh = {4'd4, 4'd4};
    hi_thresh = {4'd12, 4'd12};
    pat[0]    = 16'hFFFF;
    pat[1]    = 16'h5555;

    test_reset();
    test_transfer();
    test_debounce();
    test_sticky();
    test_bounds();
    test_mid_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
